// File: rtl/vend_pkg.sv
// Shared types for the vending controller: FSM state encoding and coin codes.
package vend_pkg;

  localparam int unsigned COIN_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_e;

  localparam logic [COIN_W-1:0] COIN_NONE = 2'b00;
  localparam logic [COIN_W-1:0] COIN_X1   = 2'b01;
  localparam logic [COIN_W-1:0] COIN_X2   = 2'b10;
  localparam logic [COIN_W-1:0] COIN_X5   = 2'b11;

  // Coin value as a multiple of UNIT; zero marks an invalid code.
  function automatic int unsigned coin_units(input logic [COIN_W-1:0] code);
    int unsigned units;
    units = 0;
    case (code)
      COIN_X1: units = 1;
      COIN_X2: units = 2;
      COIN_X5: units = 5;
      default: units = 0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-item saturating stock counters with a restock port and a single decrement port.
module vend_stock
  import vend_pkg::*;
#(
  parameter int unsigned NUM_ITEMS = 4,
  parameter int unsigned STOCK_W   = 4,
  parameter int unsigned IDX_W     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           restock_valid,
  input  logic [IDX_W-1:0]               restock_idx,
  input  logic [STOCK_W-1:0]             restock_qty,
  input  logic                           dec_valid,
  input  logic [IDX_W-1:0]               dec_idx,
  output logic [NUM_ITEMS*STOCK_W-1:0]   levels
);

  localparam int unsigned SUM_W = STOCK_W + 1;
  localparam logic [SUM_W-1:0] LEVEL_MAX = {1'b0, {STOCK_W{1'b1}}};

  logic [STOCK_W-1:0] level_q [NUM_ITEMS];
  logic [STOCK_W-1:0] level_d [NUM_ITEMS];
  logic [SUM_W-1:0]   sum;

  // Restock saturates first, then a same-cycle vend takes one unit off the saturated value.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      sum = SUM_W'(level_q[i]);
      if (restock_valid && (32'(restock_idx) == i)) begin
        sum = sum + SUM_W'(restock_qty);
      end
      if (sum > LEVEL_MAX) begin
        sum = LEVEL_MAX;
      end
      if (dec_valid && (32'(dec_idx) == i)) begin
        sum = sum - SUM_W'(1);
      end
      level_d[i] = STOCK_W'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  always_comb begin
    levels = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      levels[i*STOCK_W +: STOCK_W] = level_q[i];
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: coin credit, product selection, vend and unit-coin change refund.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned UNIT       = 5,
  parameter int unsigned MAX_CREDIT = 100,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_VEC = {8'd30, 8'd25, 8'd20, 8'd15},
  localparam int unsigned IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_code,
  input  logic                sel_valid,
  input  logic [IDX_W-1:0]    sel_idx,
  input  logic                cancel,
  input  logic                restock_valid,
  input  logic [IDX_W-1:0]    restock_idx,
  input  logic [STOCK_W-1:0]  restock_qty,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                vend_valid,
  output logic [IDX_W-1:0]    vend_idx,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                sold_out,
  output logic                insufficient
);

  state_e                       state_q, state_d;
  logic [CREDIT_W-1:0]          credit_d;
  logic                         vend_valid_d, change_d, reject_d, sold_out_d, insuff_d;
  logic [IDX_W-1:0]             vend_idx_d;
  logic                         dec_valid;
  logic [NUM_ITEMS*STOCK_W-1:0] levels;
  logic                         idx_ok;
  logic [IDX_W-1:0]             safe_idx;
  logic [STOCK_W-1:0]           sel_level;
  int unsigned                  price_val;
  int unsigned                  coin_val;

  vend_stock #(
    .NUM_ITEMS (NUM_ITEMS),
    .STOCK_W   (STOCK_W),
    .IDX_W     (IDX_W)
  ) u_stock (
    .clk           (clk),
    .rst           (rst),
    .restock_valid (restock_valid),
    .restock_idx   (restock_idx),
    .restock_qty   (restock_qty),
    .dec_valid     (dec_valid),
    .dec_idx       (sel_idx),
    .levels        (levels)
  );

  // Selected item's stock and price; out-of-range indices read item 0 but are flagged sold out.
  always_comb begin
    idx_ok    = (32'(sel_idx) < NUM_ITEMS);
    safe_idx  = idx_ok ? sel_idx : '0;
    sel_level = levels[32'(safe_idx)*STOCK_W +: STOCK_W];
    price_val = 32'(PRICE_VEC[32'(safe_idx)*CREDIT_W +: CREDIT_W]);
    coin_val  = coin_units(coin_code) * UNIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      credit       <= '0;
      busy         <= 1'b0;
      vend_valid   <= 1'b0;
      vend_idx     <= '0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      sold_out     <= 1'b0;
      insufficient <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit       <= credit_d;
      busy         <= (state_d != ST_IDLE);
      vend_valid   <= vend_valid_d;
      vend_idx     <= vend_idx_d;
      change_pulse <= change_d;
      coin_reject  <= reject_d;
      sold_out     <= sold_out_d;
      insufficient <= insuff_d;
    end
  end

  // IDLE arbitrates cancel > select > coin; VEND and CHANGE only bounce coins.
  always_comb begin
    state_d      = state_q;
    credit_d     = credit;
    vend_valid_d = 1'b0;
    vend_idx_d   = '0;
    change_d     = 1'b0;
    reject_d     = 1'b0;
    sold_out_d   = 1'b0;
    insuff_d     = 1'b0;
    dec_valid    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cancel) begin
          reject_d = coin_valid;
          if (credit != '0) begin
            state_d = ST_CHANGE;
          end
        end else if (sel_valid) begin
          reject_d = coin_valid;
          if (!idx_ok || (sel_level == '0)) begin
            sold_out_d = 1'b1;
          end else if (32'(credit) < price_val) begin
            insuff_d = 1'b1;
          end else begin
            state_d      = ST_VEND;
            vend_valid_d = 1'b1;
            vend_idx_d   = sel_idx;
            credit_d     = credit - CREDIT_W'(price_val);
            dec_valid    = 1'b1;
          end
        end else if (coin_valid) begin
          if ((coin_val != 0) && ((32'(credit) + coin_val) <= MAX_CREDIT)) begin
            credit_d = CREDIT_W'(32'(credit) + coin_val);
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_VEND: begin
        reject_d = coin_valid;
        state_d  = (credit != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        reject_d = coin_valid;
        change_d = 1'b1;
        credit_d = credit - CREDIT_W'(UNIT);
        if (credit == CREDIT_W'(UNIT)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
